pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the architectural fetch PC register and selects the next PC each cycle from reset vector, EX-stage taken branch, ID-stage jump/call/return, halt, or sequential PC+2.
- Sits between the hazard unit and the IF stage.
- Generates IF/ID flush strobes and a fetch-valid qualifier, and counts redirects for performance debug.

Parameters:
- PC_W, 16, PC width in bits.
- OFFSET_W, 10, jump offset bits used; the upper PC_W-OFFSET_W bits come from idPc.
- RESET_VECTOR, 16'h0000, PC loaded on reset.
- RAS_DEPTH, 4, return address stack entries (optional feature only).
- CNT_W, 16, redirect counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit freeze of IF/ID.
- haltReq  in  1  HALT decoded in ID.
- jumpReq  in  1  unconditional jump or call decoded in ID.
- isCall  in  1  qualifies jumpReq as a call.
- jumpOffset  in  12  raw jump field; only [OFFSET_W-1:0] used.
- idPc  in  PC_W  PC of the instruction in ID.
- retReq  in  1  return decoded in ID.
- retTarget  in  PC_W  return address read from the register file.
- branchTaken  in  1  taken branch resolved in EX.
- branchTarget  in  PC_W  resolved branch target.
- pc  out  PC_W  current fetch PC.
- fetchValid  out  1  IF fetch at pc is architecturally live.
- flushIF  out  1  squash the IF/ID register this cycle.
- flushID  out  1  squash the ID/EX register this cycle.
- halted  out  1  sequencer is in HALT.
- redirectCount  out  CNT_W  saturating count of redirects.

Behaviour:
- Reset (reset=1 at a clock edge, including mid-operation or mid-stall):
  - pc=RESET_VECTOR, state=BOOT, fetchValid=0, flushIF=0, flushID=0, halted=0, redirectCount=0.
  - RAS emptied when the optional feature is compiled in.
- FSM states: BOOT, RUN, HALT.
  - BOOT: one cycle with fetchValid=0 and pc held; then RUN.
  - RUN: fetchValid=1.
    - Next-PC priority: branchTaken > retReq > jumpReq > haltReq > stall > sequential.
    - branchTaken: pc<=branchTarget, flushIF=1, flushID=1. Stall and all ID requests are ignored because the ID instruction is squashed.
    - retReq (no branch): pc<=return address, flushIF=1.
    - jumpReq (no branch/ret): pc<={idPc[PC_W-1:OFFSET_W], jumpOffset[OFFSET_W-1:0]}, flushIF=1.
    - haltReq (no higher event): pc held, next state HALT.
    - stall only: pc held; no flush.
    - Otherwise pc<=pc+2, wrapping modulo 2^PC_W (16'hFFFE -> 16'h0000).
    - Simultaneous retReq and jumpReq is illegal decode; retReq wins.
  - HALT: pc held, fetchValid=0, halted=1, all requests ignored. Exit only by reset.
- Output timing:
  - flushIF and flushID are combinational from the same-cycle inputs while in RUN; they are 0 in BOOT and HALT.
  - The pc update is visible the next cycle, so redirect latency is 1 cycle.
- redirectCount: increments by 1 on each cycle in RUN with flushIF=1; saturates at all-ones.
- jumpOffset[11:OFFSET_W] are ignored.

Optional Feature:
- Macro PC_SEQ_RAS_EN.
- Defined: RAS_DEPTH-entry circular return address stack.
  - An accepted call (jumpReq&isCall taking effect) pushes idPc+2.
  - An accepted return pops, and its target is the top entry; when the RAS is empty, retTarget is used.
  - Overflow overwrites the oldest entry.
  - A push and a pop never coincide (mutually exclusive by priority).
  - A call or return cancelled by branchTaken does not modify the RAS.
- Undefined: no RAS storage; the return target is always retTarget and isCall is ignored.

Decomposition:
- Package pc_seq_pkg holds:
  - the state enum (BOOT, RUN, HALT);
  - the PC_INC=2 constant;
  - the redirect-source encoding (NONE, BRANCH, RET, JUMP) used for debug.
- One natural sub-module: return_addr_stack (push/pop/empty/top, depth parameter), instantiated only under PC_SEQ_RAS_EN.

Test Plan:
- Reset then idle → pc=0000 for BOOT cycle with fetchValid=0, then 0002, 0004, 0006; flushes stay 0.
- At pc=0010 with idPc=040C, jumpReq=1, jumpOffset=12'h123 → flushIF=1 that cycle, next pc=0523 {000001, 0100100011}, redirectCount=1.
- Same cycle branchTaken=1 (branchTarget=0200), jumpReq=1, stall=1 → flushIF=1, flushID=1, next pc=0200; jump ignored.
- Stall held 3 cycles at pc=0020 → pc stays 0020, no flush; release → 0022. Then pc=FFFE sequential → 0000.
- haltReq at pc=0030 → halted=1 and fetchValid=0 next cycle; jumpReq applied while halted leaves pc=0030; reset asserted → pc=0000, BOOT.
- With PC_SEQ_RAS_EN: 5 calls from idPc 0100,0200,0300,0400,0500, then 5 returns with retTarget=0BAD → targets 0502, 0402, 0302, 0202, then 0BAD. Without the macro, every return targets retTarget.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the fetch PC sequencer
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  localparam int PC_INC = 2;

  // Which event moved the PC this cycle; kept for debug probing.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_RET    = 2'd2,
    SRC_JUMP   = 2'd3
  } redirect_src_t;

endpackage

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - circular return address stack, oldest entry lost on overflow
module return_addr_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic         empty,
  output logic [W-1:0] top
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [IW-1:0] top_idx;
  logic [CW-1:0] count;

  function automatic logic [IW-1:0] idx_next(input logic [IW-1:0] i);
    return (i == IW'(DEPTH - 1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [IW-1:0] idx_prev(input logic [IW-1:0] i);
    return (i == '0) ? IW'(DEPTH - 1) : i - 1'b1;
  endfunction

  assign empty = (count == '0);
  assign top   = mem[top_idx];

  // Pushing onto a full stack advances past the oldest slot; count stays at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      top_idx <= '0;
      count   <= '0;
    end else if (push) begin
      mem[idx_next(top_idx)] <= push_data;
      top_idx                <= idx_next(top_idx);
      if (count != CW'(DEPTH)) count <= count + 1'b1;
    end else if (pop && !empty) begin
      top_idx <= idx_prev(top_idx);
      count   <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC select, IF/ID flush and redirect counter; PC_SEQ_RAS_EN adds a return stack
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W         = 16,
  parameter int              OFFSET_W     = 10,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             haltReq,
  input  logic             jumpReq,
  input  logic             isCall,
  input  logic [11:0]      jumpOffset,
  input  logic [PC_W-1:0]  idPc,
  input  logic             retReq,
  input  logic [PC_W-1:0]  retTarget,
  input  logic             branchTaken,
  input  logic [PC_W-1:0]  branchTarget,
  output logic [PC_W-1:0]  pc,
  output logic             fetchValid,
  output logic             flushIF,
  output logic             flushID,
  output logic             halted,
  output logic [CNT_W-1:0] redirectCount
);

  seq_state_t    state, next_state;
  redirect_src_t src;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] ret_addr;
  logic [PC_W-1:0] jump_target;
  logic            unused_bits;

  assign jump_target = {idPc[PC_W-1:OFFSET_W], jumpOffset[OFFSET_W-1:0]};

`ifdef PC_SEQ_RAS_EN
  logic            ras_push, ras_pop, ras_empty;
  logic [PC_W-1:0] ras_top;

  // Only requests that actually take effect touch the stack.
  assign ras_pop  = (state == RUN) && !branchTaken && retReq;
  assign ras_push = (state == RUN) && !branchTaken && !retReq && jumpReq && isCall;
  assign ret_addr = ras_empty ? retTarget : ras_top;

  return_addr_stack #(
    .DEPTH(RAS_DEPTH),
    .W    (PC_W)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(idPc + PC_W'(PC_INC)),
    .empty    (ras_empty),
    .top      (ras_top)
  );

  assign unused_bits = ^{jumpOffset[11:OFFSET_W], src};
`else
  assign ret_addr    = retTarget;
  assign unused_bits = ^{jumpOffset[11:OFFSET_W], src, isCall};
`endif

  always_comb begin
    next_state = state;
    next_pc    = pc;
    flushIF    = 1'b0;
    flushID    = 1'b0;
    fetchValid = 1'b0;
    halted     = 1'b0;
    src        = SRC_NONE;
    case (state)
      BOOT: next_state = RUN;
      RUN: begin
        fetchValid = 1'b1;
        if (branchTaken) begin
          next_pc = branchTarget;
          flushIF = 1'b1;
          flushID = 1'b1;
          src     = SRC_BRANCH;
        end else if (retReq) begin
          next_pc = ret_addr;
          flushIF = 1'b1;
          src     = SRC_RET;
        end else if (jumpReq) begin
          next_pc = jump_target;
          flushIF = 1'b1;
          src     = SRC_JUMP;
        end else if (haltReq) begin
          next_state = HALT;
        end else if (!stall) begin
          next_pc = pc + PC_W'(PC_INC);
        end
      end
      HALT: halted = 1'b1;
      default: next_state = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= BOOT;
      pc            <= RESET_VECTOR;
      redirectCount <= '0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      if (flushIF && (redirectCount != '1)) redirectCount <= redirectCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer against a queue-based model
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, haltReq, jumpReq, isCall, retReq, branchTaken;
  logic [11:0] jumpOffset;
  logic [15:0] idPc, retTarget, branchTarget;
  logic [15:0] pc;
  logic        fetchValid, flushIF, flushID, halted;
  logic [3:0]  redirectCount;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m_pc;
  int          m_state;
  int          m_cnt;
  logic [15:0] m_ras[$];

  pc_sequencer #(
    .PC_W(16), .OFFSET_W(10), .RESET_VECTOR(16'h0000), .RAS_DEPTH(4), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .haltReq(haltReq), .jumpReq(jumpReq),
    .isCall(isCall), .jumpOffset(jumpOffset), .idPc(idPc), .retReq(retReq),
    .retTarget(retTarget), .branchTaken(branchTaken), .branchTarget(branchTarget),
    .pc(pc), .fetchValid(fetchValid), .flushIF(flushIF), .flushID(flushID),
    .halted(halted), .redirectCount(redirectCount)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    reset = 0; stall = 0; haltReq = 0; jumpReq = 0; isCall = 0; retReq = 0;
    branchTaken = 0; jumpOffset = 12'h0; idPc = 16'h0; retTarget = 16'h0; branchTarget = 16'h0;
  endtask

  function automatic logic exp_fif();
    return (m_state == 1) && (branchTaken || retReq || jumpReq);
  endfunction

  function automatic logic exp_fid();
    return (m_state == 1) && branchTaken;
  endfunction

  task automatic bump();
    if (m_cnt < 15) m_cnt++;
  endtask

  // Model: 0 = boot, 1 = running, 2 = halted; applies the priority rules at each edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_pc = 16'h0000; m_state = 0; m_cnt = 0; m_ras.delete();
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (branchTaken) begin
        m_pc = branchTarget; bump();
      end else if (retReq) begin
        m_pc = retTarget;
`ifdef PC_SEQ_RAS_EN
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
`endif
        bump();
      end else if (jumpReq) begin
`ifdef PC_SEQ_RAS_EN
        if (isCall) begin
          if (m_ras.size() == 4) void'(m_ras.pop_front());
          m_ras.push_back(idPc + 16'd2);
        end
`endif
        m_pc = (idPc & 16'hFC00) | {6'd0, jumpOffset[9:0]};
        bump();
      end else if (haltReq) begin
        m_state = 2;
      end else if (!stall) begin
        m_pc = m_pc + 16'd2;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; jumpReq = 1; branchTaken = 1; branchTarget = 16'h1234;
    tick();
    idle_inputs();
    jumpReq = 1; idPc = 16'h0400; jumpOffset = 12'h055;
    #1;
    vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL reset_pc: got %h want 0000", pc); end
    vectors++; if (fetchValid !== 1'b0) begin miscompares++; $display("FAIL reset_fetchValid: got %b want 0", fetchValid); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
    vectors++; if (redirectCount !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", redirectCount); end
    vectors++; if (flushIF !== 1'b0 || flushID !== 1'b0) begin miscompares++; $display("FAIL boot_flush: got %b%b want 00", flushIF, flushID); end
    tick();
    idle_inputs();
  endtask

  task automatic test_sequential();
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'h0000; exp_seq[1] = 16'h0002; exp_seq[2] = 16'h0004; exp_seq[3] = 16'h0006;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (pc !== exp_seq[i] || pc !== m_pc) begin miscompares++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, exp_seq[i]); end
      vectors++; if (fetchValid !== 1'b1 || flushIF !== 1'b0) begin miscompares++; $display("FAIL seq_valid[%0d]: got fv=%b fif=%b want 1 0", i, fetchValid, flushIF); end
      if (i < 3) tick();
    end
  endtask

  task automatic test_jump();
    while (m_pc != 16'h0010) tick();
    jumpReq = 1; idPc = 16'h040C; jumpOffset = 12'h123;
    #1;
    vectors++; if (flushIF !== 1'b1 || flushID !== 1'b0) begin miscompares++; $display("FAIL jump_flush: got %b%b want 10", flushIF, flushID); end
    tick();
    idle_inputs();
    vectors++; if (pc !== 16'h0523) begin miscompares++; $display("FAIL jump_pc: got %h want 0523", pc); end
    vectors++; if (redirectCount !== 4'd1) begin miscompares++; $display("FAIL jump_count: got %0d want 1", redirectCount); end
    jumpReq = 1; idPc = 16'hA800; jumpOffset = 12'hD23;
    tick();
    idle_inputs();
    vectors++; if (pc !== 16'hA923) begin miscompares++; $display("FAIL jump_upper_ignored: got %h want a923", pc); end
  endtask

  task automatic test_branch_priority();
    branchTaken = 1; branchTarget = 16'h0200; jumpReq = 1; stall = 1; retReq = 1; haltReq = 1;
    idPc = 16'h0700; jumpOffset = 12'h0FF; retTarget = 16'h0BAD;
    #1;
    vectors++; if (flushIF !== 1'b1 || flushID !== 1'b1) begin miscompares++; $display("FAIL branch_flush: got %b%b want 11", flushIF, flushID); end
    tick();
    idle_inputs();
    vectors++; if (pc !== 16'h0200) begin miscompares++; $display("FAIL branch_pc: got %h want 0200", pc); end
    vectors++; if (halted !== 1'b0 || redirectCount !== m_cnt[3:0]) begin miscompares++; $display("FAIL branch_state: got h=%b cnt=%0d want 0 %0d", halted, redirectCount, m_cnt); end
  endtask

  task automatic test_stall_wrap();
    branchTaken = 1; branchTarget = 16'h0020;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      stall = 1;
      #1;
      vectors++; if (flushIF !== 1'b0 || flushID !== 1'b0) begin miscompares++; $display("FAIL stall_flush[%0d]: got %b%b want 00", i, flushIF, flushID); end
      tick();
      vectors++; if (pc !== 16'h0020) begin miscompares++; $display("FAIL stall_pc[%0d]: got %h want 0020", i, pc); end
    end
    stall = 0;
    tick();
    vectors++; if (pc !== 16'h0022) begin miscompares++; $display("FAIL stall_release: got %h want 0022", pc); end
    branchTaken = 1; branchTarget = 16'hFFFE;
    tick();
    idle_inputs();
    tick();
    vectors++; if (pc !== 16'h0000 || pc !== m_pc) begin miscompares++; $display("FAIL wrap_pc: got %h want 0000", pc); end
  endtask

  task automatic test_halt();
    branchTaken = 1; branchTarget = 16'h0030;
    tick();
    idle_inputs();
    haltReq = 1;
    tick();
    idle_inputs();
    vectors++; if (halted !== 1'b1 || fetchValid !== 1'b0) begin miscompares++; $display("FAIL halt_enter: got h=%b fv=%b want 1 0", halted, fetchValid); end
    jumpReq = 1; idPc = 16'h0400; jumpOffset = 12'h111; branchTaken = 1; branchTarget = 16'h0777;
    #1;
    vectors++; if (flushIF !== 1'b0 || flushID !== 1'b0) begin miscompares++; $display("FAIL halt_flush: got %b%b want 00", flushIF, flushID); end
    tick();
    idle_inputs();
    vectors++; if (pc !== 16'h0030 || halted !== 1'b1) begin miscompares++; $display("FAIL halt_hold: got pc=%h h=%b want 0030 1", pc, halted); end
    reset = 1;
    tick();
    idle_inputs();
    vectors++; if (pc !== 16'h0000 || halted !== 1'b0 || fetchValid !== 1'b0) begin miscompares++; $display("FAIL halt_reset: got pc=%h h=%b fv=%b want 0000 0 0", pc, halted, fetchValid); end
    tick();
  endtask

  task automatic test_ras();
    logic [15:0] exp_ret [5];
`ifdef PC_SEQ_RAS_EN
    exp_ret[0] = 16'h0502; exp_ret[1] = 16'h0402; exp_ret[2] = 16'h0302; exp_ret[3] = 16'h0202;
`else
    exp_ret[0] = 16'h0BAD; exp_ret[1] = 16'h0BAD; exp_ret[2] = 16'h0BAD; exp_ret[3] = 16'h0BAD;
`endif
    exp_ret[4] = 16'h0BAD;
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      jumpReq = 1; isCall = 1; idPc = 16'((i + 1) * 256); jumpOffset = 12'h040;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      retReq = 1; retTarget = 16'h0BAD;
      tick();
      vectors++; if (pc !== exp_ret[i] || pc !== m_pc) begin miscompares++; $display("FAIL ras_ret[%0d]: got %h want %h", i, pc, exp_ret[i]); end
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      jumpReq = 1; idPc = 16'($urandom); jumpOffset = 12'($urandom);
      tick();
    end
    idle_inputs();
    vectors++; if (redirectCount !== 4'hF || m_cnt != 15) begin miscompares++; $display("FAIL count_saturate: got %0d want 15", redirectCount); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 24) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      haltReq      = ($urandom_range(0, 39) == 0);
      jumpReq      = ($urandom_range(0, 5) == 0);
      isCall       = 1'($urandom);
      retReq       = ($urandom_range(0, 7) == 0);
      branchTaken  = ($urandom_range(0, 5) == 0);
      jumpOffset   = 12'($urandom);
      idPc         = 16'($urandom);
      retTarget    = 16'($urandom);
      branchTarget = 16'($urandom);
      #1;
      if (!reset) begin
        vectors++; if (flushIF !== exp_fif() || flushID !== exp_fid()) begin miscompares++; $display("FAIL rand_flush[%0d]: got %b%b want %b%b", i, flushIF, flushID, exp_fif(), exp_fid()); end
      end
      tick();
      vectors++;
      if (pc !== m_pc || fetchValid !== (m_state == 1) || halted !== (m_state == 2) || redirectCount !== m_cnt[3:0]) begin
        miscompares++;
        $display("FAIL rand_state[%0d]: got pc=%h fv=%b h=%b cnt=%0d want pc=%h st=%0d cnt=%0d",
                 i, pc, fetchValid, halted, redirectCount, m_pc, m_state, m_cnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_pc = 16'h0; m_state = 0; m_cnt = 0;
    test_reset();
    test_sequential();
    test_jump();
    test_branch_priority();
    test_stall_wrap();
    test_halt();
    test_ras();
    test_saturation();
    reset = 1;
    tick();
    idle_inputs();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
